// File: rtl/joystick_iface.sv
// joystick_iface
// Maps the keyboard-emulated joystick and a debounced DB9 joystick onto the
// Spectrum joystick standards that the JOYCONF register selects. It provides
// Kempston/Fuller port read data and active-low keyboard-matrix column
// contributions for the Sinclair and Cursor standards.
//
// Ports:
//   clk, rst                       system clock, synchronous active-high reset
//   kbdjoy_in[4:0]                 keyboard joystick, active-high {fire,up,down,left,right}
//   db9joy_in[4:0]                 DB9 pins, active-low, asynchronous, same order
//   zxuno_addr/regrd/regwr, din    ZX-Uno register access
//   dout, oe_n_joyconf             JOYCONF read data / output enable
//   port_addr, iorq_rd             CPU I/O read decode
//   kempston_dout, oe_n_kempston   Kempston port (0x1F)
//   fuller_dout, oe_n_fuller       Fuller port (0x7F)
//   rows[7:0]                      keyboard row select, active-low
//   joy_cols[4:0]                  column contribution, active-low
module joystick_iface #(
  parameter logic [7:0]  JOYCONF         = 8'h06,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] AUTOFIRE_HALF   = 24'd1750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] kbdjoy_in,
  input  logic [4:0] db9joy_in,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n_joyconf,
  input  logic [7:0] port_addr,
  input  logic       iorq_rd,
  output logic [7:0] kempston_dout,
  output logic       oe_n_kempston,
  output logic [7:0] fuller_dout,
  output logic       oe_n_fuller,
  input  logic [7:0] rows,
  output logic [4:0] joy_cols
);

  localparam logic [2:0] MODE_KEMPSTON  = 3'd1;
  localparam logic [2:0] MODE_SINCLAIR1 = 3'd2;
  localparam logic [2:0] MODE_SINCLAIR2 = 3'd3;
  localparam logic [2:0] MODE_CURSOR    = 3'd4;
  localparam logic [2:0] MODE_FULLER    = 3'd5;

  logic [7:0]  joyconf;
  logic [4:0]  kbd_q;
  logic [4:0]  db9_s1, db9_s2;
  logic [4:0]  db9_acc;
  logic [15:0] db_cnt [5];
  logic [23:0] af_cnt;
  logic        phase;

  // Configuration register
  always_ff @(posedge clk) begin
    if (rst)
      joyconf <= 8'h11;
    else if (zxuno_addr == JOYCONF && zxuno_regwr)
      joyconf <= din;
  end

  assign dout         = joyconf;
  assign oe_n_joyconf = ~(zxuno_addr == JOYCONF && zxuno_regrd);

  // Keyboard joystick: one register stage
  always_ff @(posedge clk) begin
    if (rst)
      kbd_q <= 5'b00000;
    else
      kbd_q <= kbdjoy_in;
  end

  // DB9: synchronizer resets to the idle (released, high) pin level so the
  // active-high view is all zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      db9_s1 <= 5'b11111;
      db9_s2 <= 5'b11111;
    end else begin
      db9_s1 <= db9joy_in;
      db9_s2 <= db9_s1;
    end
  end

  // Per-bit debounce: the counter runs only while the synchronized level
  // disagrees with the accepted level; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      db9_acc <= 5'b00000;
      for (int i = 0; i < 5; i++) db_cnt[i] <= 16'd0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (~db9_s2[i] != db9_acc[i]) begin
          if (db_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
            db9_acc[i] <= ~db9_s2[i];
            db_cnt[i]  <= 16'd0;
          end else begin
            db_cnt[i]  <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= 16'd0;
        end
      end
    end
  end

  // Autofire phase generator, shared by both sources
  always_ff @(posedge clk) begin
    if (rst) begin
      af_cnt <= 24'd0;
      phase  <= 1'b1;
    end else if (af_cnt == AUTOFIRE_HALF - 24'd1) begin
      af_cnt <= 24'd0;
      phase  <= ~phase;
    end else begin
      af_cnt <= af_cnt + 24'd1;
    end
  end

  logic [2:0] kbd_mode, db9_mode;
  logic [4:0] kbd_eff, db9_eff;

  assign kbd_mode = joyconf[2:0];
  assign db9_mode = joyconf[6:4];
  assign kbd_eff  = {kbd_q[4] & (phase | ~joyconf[3]), kbd_q[3:0]};
  assign db9_eff  = {db9_acc[4] & (phase | ~joyconf[7]), db9_acc[3:0]};

  // Per-standard joystick state, ORed across the sources in that mode.
  // Bit order stays {fire, up, down, left, right}.
  logic [4:0] k_st, f_st, s1_st, s2_st, c_st;

  always_comb begin
    k_st  = (kbd_mode == MODE_KEMPSTON  ? kbd_eff : 5'b0) | (db9_mode == MODE_KEMPSTON  ? db9_eff : 5'b0);
    f_st  = (kbd_mode == MODE_FULLER    ? kbd_eff : 5'b0) | (db9_mode == MODE_FULLER    ? db9_eff : 5'b0);
    s1_st = (kbd_mode == MODE_SINCLAIR1 ? kbd_eff : 5'b0) | (db9_mode == MODE_SINCLAIR1 ? db9_eff : 5'b0);
    s2_st = (kbd_mode == MODE_SINCLAIR2 ? kbd_eff : 5'b0) | (db9_mode == MODE_SINCLAIR2 ? db9_eff : 5'b0);
    c_st  = (kbd_mode == MODE_CURSOR    ? kbd_eff : 5'b0) | (db9_mode == MODE_CURSOR    ? db9_eff : 5'b0);
  end

  assign kempston_dout = {3'b000, k_st};
  assign fuller_dout   = {~f_st[4], 3'b111, ~f_st[0], ~f_st[1], ~f_st[2], ~f_st[3]};
  assign oe_n_kempston = ~(iorq_rd && port_addr == 8'h1F);
  assign oe_n_fuller   = ~(iorq_rd && port_addr == 8'h7F);

  // Pressed keys per matrix row, columns [4:0]. Only rows 3 (1..5) and
  // 4 (0..6) carry joystick keys.
  logic [4:0] row_press [8];

  always_comb begin
    for (int r = 0; r < 8; r++) row_press[r] = 5'b00000;
    row_press[3] = {s2_st[4] | c_st[1], s2_st[3], s2_st[2], s2_st[0], s2_st[1]};
    row_press[4] = {s1_st[1] | c_st[2], s1_st[0] | c_st[3], s1_st[2] | c_st[0],
                    s1_st[3], s1_st[4] | c_st[4]};
  end

  always_comb begin
    joy_cols = 5'b11111;
    for (int r = 0; r < 8; r++)
      joy_cols = joy_cols & ~(row_press[r] & {5{~rows[r]}});
  end

endmodule

// File: tb/tb_joystick_iface.sv
// Directed self-checking bench for joystick_iface, using short debounce and
// autofire periods so the timing behaviour can be exercised quickly.
module tb_joystick_iface;

  localparam int DEB  = 16;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] kbdjoy_in, db9joy_in;
  logic [7:0] zxuno_addr, din, port_addr, rows;
  logic       zxuno_regrd, zxuno_regwr, iorq_rd;
  logic [7:0] dout, kempston_dout, fuller_dout;
  logic       oe_n_joyconf, oe_n_kempston, oe_n_fuller;
  logic [4:0] joy_cols;

  int checks = 0;
  int errors = 0;

  joystick_iface #(
    .JOYCONF(8'h06),
    .DEBOUNCE_CYCLES(16'(DEB)),
    .AUTOFIRE_HALF(24'(HALF))
  ) dut (
    .clk(clk), .rst(rst),
    .kbdjoy_in(kbdjoy_in), .db9joy_in(db9joy_in),
    .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .din(din), .dout(dout), .oe_n_joyconf(oe_n_joyconf),
    .port_addr(port_addr), .iorq_rd(iorq_rd),
    .kempston_dout(kempston_dout), .oe_n_kempston(oe_n_kempston),
    .fuller_dout(fuller_dout), .oe_n_fuller(oe_n_fuller),
    .rows(rows), .joy_cols(joy_cols)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [7:0] v);
    zxuno_addr  = 8'h06;
    din         = v;
    zxuno_regwr = 1'b1;
    tick();
    zxuno_regwr = 1'b0;
    zxuno_addr  = 8'h00;
  endtask

  initial begin
    logic       prev, v, found;
    rst = 1'b1; kbdjoy_in = 5'b0; db9joy_in = 5'b11111;
    zxuno_addr = 8'h00; din = 8'h00; zxuno_regrd = 1'b0; zxuno_regwr = 1'b0;
    port_addr = 8'h00; iorq_rd = 1'b0; rows = 8'hFF;
    tick();
    // write during reset must be ignored
    zxuno_addr = 8'h06; din = 8'h55; zxuno_regwr = 1'b1;
    tick();
    zxuno_regwr = 1'b0; zxuno_addr = 8'h00;
    chk("reset_joyconf", dout, 8'h11);
    chk("reset_kempston", kempston_dout, 8'h00);
    chk("reset_fuller", fuller_dout, 8'hFF);
    rows = 8'h00; #1;
    chk("reset_cols", {3'b0, joy_cols}, 8'h1F);
    rows = 8'hFF;
    rst = 1'b0;
    tick();

    // 1: register read decode, Kempston from keyboard
    zxuno_addr = 8'h06; zxuno_regrd = 1'b1; #1;
    chk("oe_joyconf_sel", {7'b0, oe_n_joyconf}, 8'h00);
    chk("joyconf_read", dout, 8'h11);
    zxuno_addr = 8'h07; #1;
    chk("oe_joyconf_addr", {7'b0, oe_n_joyconf}, 8'h01);
    zxuno_addr = 8'h06; zxuno_regrd = 1'b0; #1;
    chk("oe_joyconf_nord", {7'b0, oe_n_joyconf}, 8'h01);
    zxuno_addr = 8'h00;
    iorq_rd = 1'b1; port_addr = 8'h1F; #1;
    chk("oe_kempston", {6'b0, oe_n_kempston, oe_n_fuller}, 8'h01);
    port_addr = 8'h7F; #1;
    chk("oe_fuller", {6'b0, oe_n_kempston, oe_n_fuller}, 8'h02);
    iorq_rd = 1'b0; #1;
    chk("oe_none", {6'b0, oe_n_kempston, oe_n_fuller}, 8'h03);
    kbdjoy_in = 5'b10001; #1;
    chk("kemp_before_edge", kempston_dout, 8'h00);
    tick();
    chk("kemp_fire_right", kempston_dout, 8'h11);

    // 2: Fuller
    write_reg(8'h05);
    chk("joyconf_wr05", dout, 8'h05);
    kbdjoy_in = 5'b01000;
    tick();
    chk("fuller_up", fuller_dout, 8'hFE);
    chk("kemp_off", kempston_dout, 8'h00);
    kbdjoy_in = 5'b10010;
    tick();
    chk("fuller_fire_left", fuller_dout, 8'h7B);

    // 3: Sinclair1
    write_reg(8'h02);
    kbdjoy_in = 5'b10000; rows = 8'hEF;
    tick();
    chk("s1_fire_row4", {3'b0, joy_cols}, 8'h1E);
    rows = 8'hF7; #1;
    chk("s1_fire_row3", {3'b0, joy_cols}, 8'h1F);
    kbdjoy_in = 5'b00010; rows = 8'hEF;
    tick();
    chk("s1_left_row4", {3'b0, joy_cols}, 8'h0F);

    // Sinclair2
    write_reg(8'h03);
    kbdjoy_in = 5'b00011; rows = 8'hF7;
    tick();
    chk("s2_left_right", {3'b0, joy_cols}, 8'h1C);

    // 4: Cursor
    write_reg(8'h04);
    kbdjoy_in = 5'b00010; rows = 8'hF7;
    tick();
    chk("cur_left", {3'b0, joy_cols}, 8'h0F);
    kbdjoy_in = 5'b00011; rows = 8'hE7;
    tick();
    chk("cur_left_right", {3'b0, joy_cols}, 8'h0B);
    kbdjoy_in = 5'b00000;
    rows = 8'hFF;

    // 5: DB9 debounce, keyboard off
    write_reg(8'h10);
    db9joy_in = 5'b11110;
    for (int i = 0; i < DEB / 2; i++) tick();
    db9joy_in = 5'b11111;
    for (int i = 0; i < DEB + 4; i++) begin
      tick();
      chk("db9_glitch", kempston_dout, 8'h00);
    end
    db9joy_in = 5'b11110;
    for (int i = 1; i <= DEB + 1; i++) tick();
    chk("db9_before_accept", kempston_dout, 8'h00);
    tick();
    chk("db9_accept", kempston_dout, 8'h01);
    tick();
    db9joy_in = 5'b11111;
    for (int i = 0; i < DEB + 2; i++) tick();
    chk("db9_release", kempston_dout, 8'h00);

    // 6: autofire on keyboard Kempston
    write_reg(8'h19);
    kbdjoy_in = 5'b10000;
    tick();
    prev = kempston_dout[4];
    found = 1'b0;
    for (int i = 0; i < 3 * HALF && !found; i++) begin
      tick();
      if (kempston_dout[4] !== prev) found = 1'b1;
    end
    chk("af_toggle_seen", {7'b0, found}, 8'h01);
    v = kempston_dout[4];
    for (int k = 1; k <= 3 * HALF; k++) begin
      tick();
      chk("af_phase", {7'b0, kempston_dout[4]}, {7'b0, v ^ ((k / HALF) % 2 == 1)});
    end
    for (int i = 0; i < HALF / 2; i++) tick();
    rst = 1'b1;
    tick();
    chk("rst_fire", {7'b0, kempston_dout[4]}, 8'h00);
    chk("rst_joyconf", dout, 8'h11);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/joystick_iface.md
Name: joystick_iface

Overview:
- Consumes the 5-bit keyboard-emulated joystick (`joy[4:0]`) produced by the PS/2 keyboard block, plus a raw DB9 joystick.
- Maps each source onto one of several Spectrum joystick standards. Standards are selected by a ZX-Uno configuration register.
- Produces the Kempston and Fuller I/O port read data.
- Produces active-low column contributions that the top level ANDs into the keyboard matrix `cols` for Sinclair and Cursor emulation.

Parameters:
- JOYCONF, 8'h06, ZX-Uno register address of the joystick configuration register.
- DEBOUNCE_CYCLES, 16'd50000, number of clk cycles a DB9 input must be stable before it is accepted.
- AUTOFIRE_HALF, 24'd1750000, number of clk cycles per autofire phase (half period).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- kbdjoy_in  in  5  keyboard joystick, active-high: [4]fire [3]up [2]down [1]left [0]right
- db9joy_in  in  5  DB9 pins, active-low, asynchronous, same bit order
- zxuno_addr  in  8  current ZX-Uno register address
- zxuno_regrd  in  1  register read strobe
- zxuno_regwr  in  1  register write strobe
- din  in  8  CPU data bus
- dout  out  8  JOYCONF read data
- oe_n_joyconf  out  1  low while zxuno_addr==JOYCONF && zxuno_regrd
- port_addr  in  8  CPU A[7:0]
- iorq_rd  in  1  active-high I/O read cycle
- kempston_dout  out  8  Kempston port data
- oe_n_kempston  out  1  low when iorq_rd && port_addr==8'h1F
- fuller_dout  out  8  Fuller port data
- oe_n_fuller  out  1  low when iorq_rd && port_addr==8'h7F
- rows  in  8  keyboard row select, active-low (A8..A15)
- joy_cols  out  5  column contribution, active-low

Behaviour:

JOYCONF register:
- Field layout: [2:0] kbd mode, [3] kbd autofire, [6:4] DB9 mode, [7] DB9 autofire.
- Mode encoding: 0 off, 1 Kempston, 2 Sinclair1, 3 Sinclair2, 4 Cursor, 5 Fuller. Modes 6 and 7 behave as off.
- Reset value is 8'h11 (both sources Kempston, autofire off).
- On a clk edge where zxuno_addr==JOYCONF && zxuno_regwr, the register loads din. The new mode takes effect from the next cycle.
- dout is always the register contents. oe_n_joyconf is combinational from its inputs.

DB9 input path:
- Two-flop synchronizer, then inversion to active-high.
- One debounce counter per bit. The counter resets on any change of the synchronized value versus the accepted value. The accepted bit updates when the counter reaches DEBOUNCE_CYCLES-1.
- Accepted DB9 state resets to 5'b00000.
- Total DB9 latency is 2 + DEBOUNCE_CYCLES cycles.

kbdjoy_in path:
- Registered once, giving 1-cycle latency. Reset value 0.

Autofire:
- A free-running counter toggles `phase` when it reaches AUTOFIRE_HALF-1, then wraps to 0.
- Reset: counter 0, phase 1.
- Per source, when its autofire bit is set, effective fire = held fire AND phase. Otherwise effective fire = held fire.

Port data (combinational from registered state):
- Source bits: K = sources in mode 1; F = sources in mode 5. Bits are ORed across sources.
- kempston_dout = {3'b000, K.fire, K.up, K.down, K.left, K.right}.
- fuller_dout = {~F.fire, 3'b111, ~F.right, ~F.left, ~F.down, ~F.up}.
- With no source in a given mode, kempston_dout is 8'h00 and fuller_dout is 8'hFF.

Matrix injection:
- A key is pressed if any source in the matching mode asserts the direction.
- joy_cols[c] = 0 iff some pressed key sits in column c of a row r with rows[r]==0.
- Sinclair1, row 4: fire → col0 ('0'), up → col1 ('9'), down → col2 ('8'), right → col3 ('7'), left → col4 ('6').
- Sinclair2, row 3: left → col0 ('1'), right → col1 ('2'), down → col2 ('3'), up → col3 ('4'), fire → col4 ('5').
- Cursor: left → row3 col4 ('5'); down → row4 col4 ('6'); up → row4 col3 ('7'); right → row4 col2 ('8'); fire → row4 col0 ('0').
- If multiple rows are selected, column contributions are ANDed (any match pulls low).
- With no match, joy_cols is 5'b11111.

Reset and simultaneous events:
- During reset, and in the cycle after it, all joystick state is 0.
- Reset mid-debounce discards partial counts.
- A write during reset is ignored.
- Two sources in the same mode are ORed. Sources in different modes act independently.

Test Plan:
1. After reset, read JOYCONF → dout=8'h11, oe_n_joyconf=0 only while zxuno_addr=06 && zxuno_regrd. Then kbdjoy_in=5'b10001 → kempston_dout=8'h11 from the cycle after the input is applied.
2. Write 8'h05 to JOYCONF, then kbdjoy_in=5'b01000 (up) → fuller_dout=8'hFE, kempston_dout=8'h00.
3. JOYCONF=8'h02, kbdjoy_in=5'b10000, rows=8'hEF → joy_cols=5'b11110. Same input with rows=8'hF7 → joy_cols=5'b11111.
4. JOYCONF=8'h04, kbdjoy_in=5'b00010 (left), rows=8'hF7 → joy_cols=5'b01111. With rows=8'hE7 plus right also held → joy_cols=5'b01011.
5. DB9 in mode 1, db9joy_in[0] pulses low for DEBOUNCE_CYCLES/2 → no change. Held low for DEBOUNCE_CYCLES+3 cycles → kempston bit0=1 exactly 2+DEBOUNCE_CYCLES cycles after the edge.
6. JOYCONF=8'h19 (kbd Kempston + autofire, DB9 Kempston), fire held → kempston bit4 toggles every AUTOFIRE_HALF cycles. Assert rst mid-period → bit4=0 and JOYCONF=8'h11 on the next cycle.
